// File: rtl/regbank_pkg.sv
// ============================================================================
// Module      : regbank_pkg
// Description : Shared constants and arbiter state encoding for the
//               register-bank write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regbank_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int REG_DATA_W    = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int XZR_IDX       = 31;

  typedef enum logic [0:0] {
    PREF_ALU = 1'b0,
    PREF_MEM = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. Requester 0 is the ALU path and
//               requester 1 is the load path. Preference flips only on contention.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  arb_state_t state_q;
  arb_state_t state_d;

  // Grants stay low while reset is asserted, so nothing transfers during reset.
  always_comb begin
    gnt0_o  = 1'b0;
    gnt1_o  = 1'b0;
    state_d = state_q;
    if (!reset) begin
      if (req0_i && req1_i) begin
        if (state_q == PREF_ALU) begin
          gnt0_o  = 1'b1;
          state_d = PREF_MEM;
        end else begin
          gnt1_o  = 1'b1;
          state_d = PREF_ALU;
        end
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PREF_ALU;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regbank_write_arbiter.sv
// ============================================================================
// Module      : regbank_write_arbiter
// Description : Arbitrates ALU and load write-backs onto the single register
//               bank write port and tracks pending writes in a busy scoreboard.
//               Optional stall counters: define REGBANK_ARB_STALL_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int NUM_REGS   = NUM_ARCH_REGS,
  parameter int ZERO_REG   = XZR_IDX
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aluValid,
  output logic                  aluReady,
  input  logic [ADDR_WIDTH-1:0] aluReg,
  input  logic [DATA_WIDTH-1:0] aluData,
  input  logic                  memValid,
  output logic                  memReady,
  input  logic [ADDR_WIDTH-1:0] memReg,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic                  markValid,
  input  logic [ADDR_WIDTH-1:0] markReg,
  output logic [NUM_REGS-1:0]   busyMask,
  output logic [ADDR_WIDTH-1:0] regWrite,
  output logic [DATA_WIDTH-1:0] regWriteData,
  output logic                  isWrite
`ifdef REGBANK_ARB_STALL_COUNT_EN
  ,
  output logic [15:0]           aluStallCount,
  output logic [15:0]           memStallCount
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic                  grantAlu;
  logic                  grantMem;
  logic                  grantAny;
  logic [ADDR_WIDTH-1:0] grantReg;
  logic [DATA_WIDTH-1:0] grantData;

  logic [ADDR_WIDTH-1:0] regWrite_q, regWrite_d;
  logic [DATA_WIDTH-1:0] regWriteData_q, regWriteData_d;
  logic                  isWrite_q, isWrite_d;
  logic [NUM_REGS-1:0]   busyMask_q, busyMask_d;

  rr_arbiter2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .req0_i (aluValid),
    .req1_i (memValid),
    .gnt0_o (grantAlu),
    .gnt1_o (grantMem)
  );

  assign aluReady  = grantAlu;
  assign memReady  = grantMem;
  assign grantAny  = grantAlu | grantMem;
  assign grantReg  = grantAlu ? aluReg  : memReg;
  assign grantData = grantAlu ? aluData : memData;

  always_comb begin
    regWrite_d     = regWrite_q;
    regWriteData_d = regWriteData_q;
    isWrite_d      = 1'b0;
    if (grantAny) begin
      regWrite_d     = grantReg;
      regWriteData_d = grantData;
      isWrite_d      = (grantReg != ZERO_IDX);
    end
  end

  // Clear before set so a same-cycle mark of the committing register wins.
  always_comb begin
    busyMask_d = busyMask_q;
    if (grantAny) begin
      busyMask_d[grantReg] = 1'b0;
    end
    if (markValid && (markReg != ZERO_IDX)) begin
      busyMask_d[markReg] = 1'b1;
    end
    busyMask_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regWrite_q     <= '0;
      regWriteData_q <= '0;
      isWrite_q      <= 1'b0;
      busyMask_q     <= '0;
    end else begin
      regWrite_q     <= regWrite_d;
      regWriteData_q <= regWriteData_d;
      isWrite_q      <= isWrite_d;
      busyMask_q     <= busyMask_d;
    end
  end

  assign regWrite     = regWrite_q;
  assign regWriteData = regWriteData_q;
  assign isWrite      = isWrite_q;
  assign busyMask     = busyMask_q;

`ifdef REGBANK_ARB_STALL_COUNT_EN
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic [15:0] aluStall_q, aluStall_d;
  logic [15:0] memStall_q, memStall_d;

  always_comb begin
    aluStall_d = aluStall_q;
    memStall_d = memStall_q;
    if (aluValid && !aluReady && (aluStall_q != STALL_MAX)) begin
      aluStall_d = aluStall_q + 16'd1;
    end
    if (memValid && !memReady && (memStall_q != STALL_MAX)) begin
      memStall_d = memStall_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluStall_q <= '0;
      memStall_q <= '0;
    end else begin
      aluStall_q <= aluStall_d;
      memStall_q <= memStall_d;
    end
  end

  assign aluStallCount = aluStall_q;
  assign memStallCount = memStall_q;
`endif

endmodule

`default_nettype wire

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the register bank's single write port between two write-back requesters: the ALU result path and the memory-load path.
- Registers the granted write into the bank's write signals (regWrite, regWriteData, isWrite).
- Keeps a 32-bit busy scoreboard so issue logic can stall on RAW hazards.
- Sits between the execute/memory stages and the register bank.

Parameters:
- DATA_WIDTH, 64, write data width.
- ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, number of architectural registers.
- ZERO_REG, 31, hardwired-zero register (XZR). Writes to it are discarded.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- aluValid  in  1  ALU write-back request
- aluReady  out  1  ALU request granted this cycle
- aluReg  in  ADDR_WIDTH  ALU destination register
- aluData  in  DATA_WIDTH  ALU result
- memValid  in  1  load write-back request
- memReady  out  1  load request granted this cycle
- memReg  in  ADDR_WIDTH  load destination register
- memData  in  DATA_WIDTH  load data
- markValid  in  1  issue stage claims a destination register
- markReg  in  ADDR_WIDTH  register being claimed
- busyMask  out  NUM_REGS  registered scoreboard, bit i set = write to Xi pending
- regWrite  out  ADDR_WIDTH  to bank write address
- regWriteData  out  DATA_WIDTH  to bank write data
- isWrite  out  1  to bank write enable

Behaviour:
- Reset (async, active-high): isWrite=0, regWrite=0, regWriteData=0, busyMask=0, arbiter state=PREF_ALU.
  - Reset asserted mid-operation drops any in-flight grant. Requesters must re-present.
- Handshake:
  - Requester holds Valid, Reg and Data stable until it sees Ready=1.
  - Ready is combinational from both Valids and the arbiter state.
  - Valid must never depend on Ready.
  - Transfer occurs on a clock edge with Valid&&Ready.
- Arbitration (2-state FSM: PREF_ALU, PREF_MEM):
  - Exactly one requester valid: it is granted regardless of state, and the state is unchanged.
  - Both valid: the preferred one is granted, and the state toggles to prefer the other.
  - Neither valid: no grant, state unchanged.
  - At most one Ready is high per cycle.
- Write port, latency 1:
  - The edge after a grant sets regWrite=granted Reg and regWriteData=granted Data.
  - isWrite=1 for exactly one cycle, unless Reg==ZERO_REG, in which case isWrite=0.
  - Cycles with no grant: isWrite=0; regWrite and regWriteData hold their last values.
  - Back-to-back grants yield consecutive isWrite pulses, so full throughput is one write per cycle.
- Scoreboard:
  - markValid with markReg!=ZERO_REG sets busyMask[markReg] at the next edge.
  - Each grant clears busyMask[granted Reg] at the same edge that loads the write port.
  - Mark and clear of the same register in one cycle: the mark wins and the bit stays 1.
  - Marking an already-busy register leaves it 1. Issue logic must stall WAW, since a single commit clears the bit.
  - Bit ZERO_REG is always 0.
- Both requesters target the same register in one cycle: they serialise; the loser commits on a later cycle, and the bit clears on each commit.

Optional Feature:
- Macro: REGBANK_ARB_STALL_COUNT_EN.
- Defined:
  - Adds outputs aluStallCount and memStallCount, each 16-bit.
  - A counter increments on each cycle its Valid=1 and Ready=0, and saturates at 0xFFFF.
  - Both counters reset to 0.
- Undefined: the ports and logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package regbank_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=64, NUM_ARCH_REGS=32, XZR_IDX=31;
  - enum arb_state_t {PREF_ALU, PREF_MEM}.
- Natural sub-module: rr_arbiter2, a 2-way round-robin grant plus state flop, reusable elsewhere.
- Scoreboard and write-port register stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles with both Valids high -> isWrite=0, busyMask=0, both Ready=0 while reset is high.
- Single ALU write: aluValid=1, aluReg=10, aluData=5 for one cycle -> aluReady=1; next cycle regWrite=10, regWriteData=5, isWrite=1; following cycle isWrite=0.
- Contention: both valid for 4 cycles, ALU regs 1..4 and mem regs 11..14 -> grant order ALU1, MEM11, ALU2, MEM12; isWrite high on 4 consecutive cycles.
- XZR: memReg=31, memData=0xDEAD -> memReady=1, isWrite stays 0; markReg=31 -> busyMask[31] stays 0.
- Scoreboard: mark X5 -> busyMask[5]=1; commit X5 with markValid=1, markReg=5 in the same cycle -> bit stays 1; a later commit with no mark -> bit 0.
- Async reset mid-grant: assert reset between clock edges while aluValid=1 -> isWrite, busyMask and the state clear immediately; the ALU write is not committed.
